// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parameterised UART transmitter (start, DATA_BITS payload LSB first, optional parity, 1-2 stop bits)
// Ports:
//   i_clk       - clock, rising edge
//   i_rst_n     - synchronous active-low reset
//   i_tx_dv     - transmit request, taken when o_tx_ready is high
//   i_tx_data   - payload word, captured on acceptance
//   o_tx_ready  - high in IDLE when a request will be accepted
//   o_tx_serial - serial line, idle high
//   o_tx_active - high while a frame is on the line
//   o_tx_done   - one-cycle pulse in the first IDLE cycle after STOP
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_dv,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_tx_serial,
    output logic                 o_tx_active,
    output logic                 o_tx_done
);
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] D_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] S_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t                 state, state_n;
    logic [TW-1:0]          timer, timer_n;
    logic [IW-1:0]          idx, idx_n;
    logic [DATA_BITS-1:0]   data_q, data_n;
    logic                   last, par_bit, serial_n;

    assign last    = timer == T_LAST;
    // even parity is the XOR of the payload; odd mode inverts it
    assign par_bit = ^data_q ^ (PARITY == 1);

    always_comb begin
        state_n = state;
        timer_n = timer + 1'b1;
        idx_n   = idx;
        data_n  = data_q;
        case (state)
            S_IDLE: begin
                timer_n = '0;
                if (i_tx_dv && o_tx_ready) begin
                    state_n = S_START;
                    data_n  = i_tx_data;
                end
            end
            S_START: if (last) begin
                timer_n = '0;
                idx_n   = '0;
                state_n = S_DATA;
            end
            S_DATA: if (last) begin
                timer_n = '0;
                idx_n   = idx == D_LAST ? '0 : idx + 1'b1;
                if (idx == D_LAST) state_n = PARITY != 0 ? S_PAR : S_STOP;
            end
            S_PAR: if (last) begin
                timer_n = '0;
                state_n = S_STOP;
            end
            S_STOP: if (last) begin
                // idx counts stop bits here so the timer stays within one bit period
                timer_n = '0;
                idx_n   = idx == S_LAST ? '0 : idx + 1'b1;
                if (idx == S_LAST) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // line level is computed for the coming state so the output is a plain register
        serial_n = state_n == S_START ? 1'b0 :
                   state_n == S_DATA  ? data_q[idx_n] :
                   state_n == S_PAR   ? par_bit : 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            idx         <= '0;
            data_q      <= '0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
            o_tx_ready  <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            idx         <= idx_n;
            data_q      <= data_n;
            o_tx_serial <= serial_n;
            o_tx_active <= state_n != S_IDLE;
            o_tx_done   <= state == S_STOP && state_n == S_IDLE;
            o_tx_ready  <= state_n == S_IDLE;
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: checks 8N1, 8E1, 8O1 and 7N2 transmitters against a bit-list frame model
module tb_uart_tx_cfg;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dv, ready, serial, active, done;
    logic [8:0] data [4];
    int         errs = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv[0]), .i_tx_data(data[0][7:0]),
        .o_tx_ready(ready[0]), .o_tx_serial(serial[0]), .o_tx_active(active[0]), .o_tx_done(done[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv[1]), .i_tx_data(data[1][7:0]),
        .o_tx_ready(ready[1]), .o_tx_serial(serial[1]), .o_tx_active(active[1]), .o_tx_done(done[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv[2]), .i_tx_data(data[2][7:0]),
        .o_tx_ready(ready[2]), .o_tx_serial(serial[2]), .o_tx_active(active[2]), .o_tx_done(done[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_7 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv[3]), .i_tx_data(data[3][6:0]),
        .o_tx_ready(ready[3]), .o_tx_serial(serial[3]), .o_tx_active(active[3]), .o_tx_done(done[3]));

    function automatic int nb(input int k);
        return k == 3 ? 7 : 8;
    endfunction
    function automatic int pm(input int k);
        return k == 1 ? 2 : k == 2 ? 1 : 0;
    endfunction
    function automatic int sb(input int k);
        return k == 3 ? 2 : 1;
    endfunction

    // Checks a frame whose request was accepted at the posedge just passed:
    // cycles 0..L-1 carry the frame, cycle L is the done cycle.
    task automatic check_frame(input int k, input logic [8:0] d, input bit hold,
                               input logic [8:0] nd, input bit poke);
        bit q[$];
        int ones = 0;
        int len;
        logic es;
        q.push_back(1'b0);
        for (int i = 0; i < nb(k); i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pm(k) == 2) q.push_back(ones % 2 == 1);
        if (pm(k) == 1) q.push_back(ones % 2 == 0);
        for (int i = 0; i < sb(k); i++) q.push_back(1'b1);
        len = (1 + nb(k) + (pm(k) != 0 ? 1 : 0) + sb(k)) * C;
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (!hold) dv[k] = 1'b0;
                data[k] = hold ? nd : 9'($urandom);
            end
            if (poke && c == len - 2) begin
                dv[k] = 1'b1;
                data[k] = 9'($urandom);
            end
            if (poke && c == len - 1) dv[k] = 1'b0;
            es = c < len ? q[c / C] : 1'b1;
            checks++;
            if (serial[k] !== es) begin
                errs++;
                $display("FAIL serial k=%0d d=%0h c=%0d: got %b want %b", k, d, c, serial[k], es);
            end
            checks++;
            if (active[k] !== (c < len)) begin
                errs++;
                $display("FAIL active k=%0d c=%0d: got %b want %b", k, c, active[k], c < len);
            end
            checks++;
            if (done[k] !== (c == len)) begin
                errs++;
                $display("FAIL done k=%0d c=%0d: got %b want %b", k, c, done[k], c == len);
            end
            checks++;
            if (ready[k] !== (c == len)) begin
                errs++;
                $display("FAIL ready k=%0d c=%0d: got %b want %b", k, c, ready[k], c == len);
            end
        end
    endtask

    task automatic send(input int k, input logic [8:0] d);
        @(negedge clk);
        checks++;
        if (ready[k] !== 1'b1) begin
            errs++;
            $display("FAIL ready_before_send k=%0d: got %b want 1", k, ready[k]);
        end
        dv[k] = 1'b1;
        data[k] = d;
        @(posedge clk);
        check_frame(k, d, 1'b0, 9'h0, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({serial[k], active[k], done[k], ready[k]} !== 4'b1000) begin
                errs++;
                $display("FAIL reset_outputs k=%0d: got %b want 1000",
                         k, {serial[k], active[k], done[k], ready[k]});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ready[k] !== 1'b1 || serial[k] !== 1'b1) begin
                errs++;
                $display("FAIL post_reset_ready k=%0d: got r=%b s=%b want r=1 s=1", k, ready[k], serial[k]);
            end
        end
    endtask

    task automatic test_8n1;
        send(0, 9'h035);
    endtask

    task automatic test_parity;
        send(1, 9'h035);
        send(2, 9'h035);
    endtask

    task automatic test_7n2;
        send(3, 9'h07F);
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++)
            for (int k = 0; k < 4; k++) send(k, 9'($urandom));
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        dv[0] = 1'b1;
        data[0] = 9'h0A5;
        @(posedge clk);
        check_frame(0, 9'h0A5, 1'b1, 9'h05A, 1'b0);
        check_frame(0, 9'h05A, 1'b0, 9'h0, 1'b0);
    endtask

    task automatic test_reset_mid_data;
        @(negedge clk);
        dv[0] = 1'b1;
        data[0] = 9'h0FF;
        @(posedge clk);
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            if (c == 0) dv[0] = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({serial[0], active[0], done[0]} !== 3'b100) begin
            errs++;
            $display("FAIL mid_reset k=0: got s/a/d=%b want 100", {serial[0], active[0], done[0]});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({serial[0], active[0], done[0], ready[0]} !== 4'b1001) begin
                errs++;
                $display("FAIL after_mid_reset c=%0d: got %b want 1001",
                         c, {serial[0], active[0], done[0], ready[0]});
            end
        end
        send(0, 9'h000);
    endtask

    task automatic test_ignored_request;
        @(negedge clk);
        dv[0] = 1'b1;
        data[0] = 9'h0C3;
        @(posedge clk);
        check_frame(0, 9'h0C3, 1'b0, 9'h0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({serial[0], active[0], ready[0]} !== 3'b101) begin
                errs++;
                $display("FAIL ignored_req c=%0d: got s/a/r=%b want 101", c, {serial[0], active[0], ready[0]});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dv = '0;
        for (int k = 0; k < 4; k++) data[k] = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_random();
        test_back_to_back();
        test_reset_mid_data();
        test_ignored_request();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
